// File: rtl/crg_switch_sequencer.sv
// -----------------------------------------------------------------------------
// crg_switch_sequencer
//
// Control-side sequencer for the clock/reset generator. It takes one software
// clock-switch request at a time over a valid/ready handshake and walks the
// addressed channel through a safe switch:
//   gate (en low) -> dead time -> source change -> settle -> ungate
//   -> optional reset pulse -> completion pulse.
// A channel's source select only ever changes while that channel is gated.
//
// Ports
//   clk_i        reference clock (single domain)
//   arst_i       asynchronous active-high reset
//   req_valid_i  request valid
//   req_ready_o  request can be accepted (IDLE and DONE only)
//   req_ch_i     target channel index
//   req_sel_i    new source index for the target channel
//   req_rst_i    also pulse the channel's reset request during the switch
//   sel_o        per-channel source select, channel i at [i*SW +: SW]
//   en_o         per-channel clock enable
//   arst_req_o   per-channel reset request
//   busy_o       a switch sequence is in progress
//   done_o       one-cycle completion pulse
//   err_o        one-cycle pulse for a request addressing a missing channel
//
// DEAD_CYCLES, SETTLE_CYCLES and RST_CYCLES must all be at least 1.
// -----------------------------------------------------------------------------
module crg_switch_sequencer #(
    parameter int M             = 4,
    parameter int N             = 8,
    parameter int DEAD_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int RST_CYCLES    = 4,
    localparam int SW = (M > 1) ? $clog2(M) : 1,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [CW-1:0]     req_ch_i,
    input  logic [SW-1:0]     req_sel_i,
    input  logic              req_rst_i,
    output logic [N*SW-1:0]   sel_o,
    output logic [N-1:0]      en_o,
    output logic [N-1:0]      arst_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int MAX_DS = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_C  = (MAX_DS > RST_CYCLES) ? MAX_DS : RST_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEAD   = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RST    = CNT_W'(RST_CYCLES);
    localparam logic [CW:0]      N_LIM      = (CW + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAD,
        S_SETTLE,
        S_RESET,
        S_DONE
    } state_t;

    // Control state (asynchronously reset)
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N*SW-1:0]   sel_q, sel_d;
    logic [N-1:0]      en_q, en_d;
    logic [N-1:0]      arst_req_q, arst_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    // A request accepted at the previous edge, classified at acceptance time.
    logic              pend_full_q, pend_full_d;
    logic              pend_done_q, pend_done_d;
    logic              pend_err_q, pend_err_d;

    // Latched request (plain data, no reset needed)
    logic [CW-1:0]     req_ch_q, req_ch_d;
    logic [SW-1:0]     req_sel_q, req_sel_d;
    logic              req_rst_q, req_rst_d;

    logic              accept;
    logic              ch_invalid;
    logic              is_noop;
    logic [SW-1:0]     cur_sel;
    logic [N-1:0]      ch_hit;

    assign accept     = req_valid_i && ready_q;
    assign ch_invalid = ({1'b0, req_ch_i} >= N_LIM);
    assign is_noop    = !ch_invalid && (req_sel_i == cur_sel) && !req_rst_i;

    // Current source of the requested channel; loop avoids an out-of-range
    // select when the request addresses a channel that does not exist.
    always_comb begin
        cur_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (req_ch_i == CW'(i)) begin
                cur_sel = sel_q[i*SW +: SW];
            end
        end
    end

    // One-hot of the latched channel; all per-channel updates go through it so
    // untouched channels simply hold.
    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < N; i++) begin
            ch_hit[i] = (req_ch_q == CW'(i));
        end
    end

    always_comb begin
        req_ch_d  = accept ? req_ch_i  : req_ch_q;
        req_sel_d = accept ? req_sel_i : req_sel_q;
        req_rst_d = accept ? req_rst_i : req_rst_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        en_d        = en_q;
        arst_req_d  = arst_req_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        // No-op and invalid requests complete one edge after acceptance.
        done_d      = pend_done_q;
        err_d       = pend_err_q;
        pend_full_d = 1'b0;
        pend_done_d = 1'b0;
        pend_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_full_q) begin
                    en_d       = en_q & ~ch_hit;
                    arst_req_d = (arst_req_q & ~ch_hit) | (ch_hit & {N{req_rst_q}});
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    cnt_d      = CNT_DEAD;
                    state_d    = S_DEAD;
                end
            end
            S_DEAD: begin
                if (cnt_q == CNT_ONE) begin
                    for (int i = 0; i < N; i++) begin
                        if (ch_hit[i]) begin
                            sel_d[i*SW +: SW] = req_sel_q;
                        end
                    end
                    cnt_d   = CNT_SETTLE;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_ONE) begin
                    en_d = en_q | ch_hit;
                    if (req_rst_q) begin
                        cnt_d   = CNT_RST;
                        state_d = S_RESET;
                    end else begin
                        ready_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESET: begin
                if (cnt_q == CNT_ONE) begin
                    arst_req_d = arst_req_q & ~ch_hit;
                    ready_d    = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                // Ready is already high here, so the next request can be
                // taken on the same edge that raises done.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            if (ch_invalid) begin
                pend_done_d = 1'b1;
                pend_err_d  = 1'b1;
            end else if (is_noop) begin
                pend_done_d = 1'b1;
            end else begin
                pend_full_d = 1'b1;
                ready_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            en_q        <= '1;
            arst_req_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            pend_full_q <= 1'b0;
            pend_done_q <= 1'b0;
            pend_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            arst_req_q  <= arst_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            pend_full_q <= pend_full_d;
            pend_done_q <= pend_done_d;
            pend_err_q  <= pend_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        req_ch_q  <= req_ch_d;
        req_sel_q <= req_sel_d;
        req_rst_q <= req_rst_d;
    end

    assign req_ready_o = ready_q;
    assign sel_o       = sel_q;
    assign en_o        = en_q;
    assign arst_req_o  = arst_req_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_crg_switch_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for crg_switch_sequencer (N=8 main instance, N=6 instance for
// the missing-channel case), followed by a random request stream with
// invariant monitors and a source-select scoreboard.
// -----------------------------------------------------------------------------
module tb_crg_switch_sequencer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_ch = '0;
    logic [1:0]  req_sel = '0;
    logic        req_rst = 1'b0;
    logic [15:0] sel;
    logic [7:0]  en;
    logic [7:0]  arst_req;
    logic        busy, done, err;

    logic        v6 = 1'b0;
    logic        ready6;
    logic [2:0]  ch6 = '0;
    logic [1:0]  s6 = '0;
    logic        rs6 = 1'b0;
    logic [11:0] sel6;
    logic [5:0]  en6;
    logic [5:0]  ar6;
    logic        busy6, done6, err6;

    int checks = 0;
    int errors = 0;

    int sel_viol = 0;
    int en_viol  = 0;
    int rises    = 0;
    int sel_chg  = 0;

    always #5 clk = ~clk;

    crg_switch_sequencer #(.M(4), .N(8)) dut (
        .clk_i(clk), .arst_i(arst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_ch_i(req_ch), .req_sel_i(req_sel), .req_rst_i(req_rst),
        .sel_o(sel), .en_o(en), .arst_req_o(arst_req),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    crg_switch_sequencer #(.M(4), .N(6)) dut6 (
        .clk_i(clk), .arst_i(arst),
        .req_valid_i(v6), .req_ready_o(ready6),
        .req_ch_i(ch6), .req_sel_i(s6), .req_rst_i(rs6),
        .sel_o(sel6), .en_o(en6), .arst_req_o(ar6),
        .busy_o(busy6), .done_o(done6), .err_o(err6)
    );

    // Invariant monitors on the main instance, sampled on the falling edge.
    logic [15:0] sel_prev = '0;
    logic [7:0]  en_prev  = '1;
    int          low_cnt [8];

    initial begin
        for (int i = 0; i < 8; i++) low_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (arst) begin
                low_cnt[i] = 0;
            end else begin
                if (sel[i*2 +: 2] != sel_prev[i*2 +: 2]) begin
                    sel_chg++;
                    if (en[i] || en_prev[i]) sel_viol++;
                end
                if (!en[i]) begin
                    low_cnt[i]++;
                end else begin
                    if (low_cnt[i] != 0) begin
                        rises++;
                        if (low_cnt[i] < 16) en_viol++;
                    end
                    low_cnt[i] = 0;
                end
            end
        end
        sel_prev = sel;
        en_prev  = en;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Handshake: returns just after the accepting edge k.
    task automatic accept(input logic [2:0] c, input logic [1:0] s, input logic r);
        for (int i = 0; i < 100 && !req_ready; i++) tick(1);
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_ch    = c;
        req_sel   = s;
        req_rst   = r;
        req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
    endtask

    int          first_done;
    int          second_done;
    logic [15:0] exp_sel;
    logic        acc;
    int          rc;

    initial begin
        // ---------------- reset ----------------
        req_valid = 1'b1; req_ch = 3'd1; req_sel = 2'd1; req_rst = 1'b1;
        tick(3);
        chk("rst_sel", {16'd0, sel}, 32'h0);
        chk("rst_en", {24'd0, en}, 32'hff);
        chk("rst_arst", {24'd0, arst_req}, 32'h0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        req_valid = 1'b0;
        arst = 1'b0;
        tick(2);
        chk("rst_ignored_sel", {16'd0, sel}, 32'h0);
        chk("rst_ignored_done", {31'd0, done}, 32'd0);

        // ---------------- ch3 -> sel2, no reset ----------------
        accept(3'd3, 2'd2, 1'b0);
        chk("t1_ready_k", {31'd0, req_ready}, 32'd0);
        tick(1);
        chk("t1_en_k1", {24'd0, en}, 32'hf7);
        chk("t1_busy_k1", {31'd0, busy}, 32'd1);
        tick(7);
        chk("t1_sel_k8", {16'd0, sel}, 32'h0000);
        tick(1);
        chk("t1_sel_k9", {16'd0, sel}, 32'h0080);
        tick(7);
        chk("t1_en_k16", {24'd0, en}, 32'hf7);
        tick(1);
        chk("t1_en_k17", {24'd0, en}, 32'hff);
        chk("t1_done_k17", {31'd0, done}, 32'd0);
        tick(1);
        chk("t1_done_k18", {31'd0, done}, 32'd1);
        chk("t1_busy_k18", {31'd0, busy}, 32'd0);
        chk("t1_ready_k18", {31'd0, req_ready}, 32'd1);
        tick(1);
        chk("t1_done_k19", {31'd0, done}, 32'd0);

        // ---------------- ch5 -> sel1, with reset pulse ----------------
        accept(3'd5, 2'd1, 1'b1);
        tick(1);
        chk("t2_en_k1", {24'd0, en}, 32'hdf);
        chk("t2_arst_k1", {24'd0, arst_req}, 32'h20);
        chk("t2_busy_k1", {31'd0, busy}, 32'd1);
        tick(8);
        chk("t2_sel_k9", {16'd0, sel}, 32'h0480);
        tick(8);
        chk("t2_en_k17", {24'd0, en}, 32'hff);
        chk("t2_arst_k17", {24'd0, arst_req}, 32'h20);
        tick(3);
        chk("t2_arst_k20", {24'd0, arst_req}, 32'h20);
        tick(1);
        chk("t2_arst_k21", {24'd0, arst_req}, 32'h00);
        chk("t2_busy_k21", {31'd0, busy}, 32'd1);
        chk("t2_done_k21", {31'd0, done}, 32'd0);
        tick(1);
        chk("t2_done_k22", {31'd0, done}, 32'd1);
        chk("t2_busy_k22", {31'd0, busy}, 32'd0);
        tick(1);

        // ---------------- back-to-back: ch0->3 then ch7->1 ----------------
        accept(3'd0, 2'd3, 1'b0);
        req_ch = 3'd7; req_sel = 2'd1; req_rst = 1'b0; req_valid = 1'b1;
        first_done = 0;
        second_done = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 1) chk("t3_en_first", {24'd0, en}, 32'hfe);
            if (i == 19) chk("t3_en_second", {24'd0, en}, 32'h7f);
            if (done) begin
                if (first_done == 0) begin
                    first_done = i;
                    req_valid = 1'b0;
                end else if (second_done == 0) begin
                    second_done = i;
                end
            end
        end
        chk("t3_first_done", first_done, 32'd18);
        chk("t3_second_done", second_done, 32'd36);
        chk("t3_sel", {16'd0, sel}, 32'h4483);
        chk("t3_en", {24'd0, en}, 32'hff);

        // ---------------- no-op and missing channel ----------------
        accept(3'd3, 2'd2, 1'b0);
        chk("t4_noop_ready_k", {31'd0, req_ready}, 32'd1);
        tick(1);
        chk("t4_noop_done", {31'd0, done}, 32'd1);
        chk("t4_noop_err", {31'd0, err}, 32'd0);
        chk("t4_noop_busy", {31'd0, busy}, 32'd0);
        chk("t4_noop_en", {24'd0, en}, 32'hff);
        chk("t4_noop_sel", {16'd0, sel}, 32'h4483);
        tick(1);
        chk("t4_noop_done_off", {31'd0, done}, 32'd0);

        ch6 = 3'd7; s6 = 2'd1; rs6 = 1'b0; v6 = 1'b1;
        tick(1);
        v6 = 1'b0;
        chk("t4_inv_ready_k", {31'd0, ready6}, 32'd1);
        tick(1);
        chk("t4_inv_done", {31'd0, done6}, 32'd1);
        chk("t4_inv_err", {31'd0, err6}, 32'd1);
        chk("t4_inv_en", {26'd0, en6}, 32'h3f);
        chk("t4_inv_sel", {20'd0, sel6}, 32'h0);
        chk("t4_inv_busy", {31'd0, busy6}, 32'd0);
        tick(1);
        chk("t4_inv_err_off", {31'd0, err6}, 32'd0);

        // ---------------- reset in the middle of a ch2 switch ----------------
        accept(3'd2, 2'd1, 1'b0);
        tick(12);
        chk("t5_sel_k12", {16'd0, sel}, 32'h4493);
        chk("t5_en_k12", {24'd0, en}, 32'hfb);
        arst = 1'b1;
        #1;
        chk("t5_sel_async", {16'd0, sel}, 32'h0);
        chk("t5_en_async", {24'd0, en}, 32'hff);
        chk("t5_busy_async", {31'd0, busy}, 32'd0);
        chk("t5_ready_async", {31'd0, req_ready}, 32'd1);
        tick(2);
        arst = 1'b0;
        tick(1);
        chk("t5_no_done", {31'd0, done}, 32'd0);
        accept(3'd2, 2'd3, 1'b0);
        tick(17);
        chk("t5_new_done_k17", {31'd0, done}, 32'd0);
        tick(1);
        chk("t5_new_done_k18", {31'd0, done}, 32'd1);
        chk("t5_new_sel", {16'd0, sel}, 32'h0030);
        tick(1);

        // ---------------- random request stream, 10 us ----------------
        exp_sel = 16'h0030;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!req_valid && ($urandom_range(0, 3) == 0)) begin
                req_ch    = 3'($urandom_range(0, 7));
                req_sel   = 2'($urandom_range(0, 3));
                req_rst   = 1'($urandom_range(0, 1));
                req_valid = 1'b1;
            end
            acc = req_valid && req_ready;
            tick(1);
            if (acc) begin
                rc = int'(req_ch);
                exp_sel[rc*2 +: 2] = req_sel;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 100 && (busy || !req_ready); i++) tick(1);
        tick(2);
        chk("t6_idle", {30'd0, busy, req_ready}, 32'd1);
        chk("t6_sel_scoreboard", {16'd0, sel}, {16'd0, exp_sel});
        chk("t6_en", {24'd0, en}, 32'hff);
        chk("t6_arst", {24'd0, arst_req}, 32'h0);
        chk("inv_sel_gated", sel_viol, 32'd0);
        chk("inv_en_low_len", en_viol, 32'd0);
        chk("inv_rises_seen", {31'd0, rises > 0}, 32'd1);
        chk("inv_sel_changes_seen", {31'd0, sel_chg > 0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
